alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue/sequencing controller feeding the ALU result path. Accepts one decoded
//  instruction (opcode, rd, operand values), drives operands and a one-hot start
//  to the functional units, and waits out each unit's fixed latency. It then holds
//  op_opcode stable for the rd_val writeback select while presenting a writeback
//  handshake to the register file. Unpipelined: one instruction in flight.
// PARAMETERS
//  N        16  operand/result data width
//  SEL_LINE 4   opcode width (matches writeback select)
//  RADDR    4   destination register address width
//  MUL_LAT  3   cycles from op_start to valid mul result (>=1)
//  DIV_LAT  16  cycles from op_start to valid div result (>=1)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         instruction offered
//  in_ready   out  1         controller can accept (IDLE)
//  in_opcode  in   SEL_LINE  0 add,1 sub,2 mul,3 div,4 and,5 or,6 xor; 7..15 illegal
//  in_rd      in   RADDR     destination register
//  in_rs1_val in   N         operand A
//  in_rs2_val in   N         operand B
//  op_a       out  N         registered operand A to all units
//  op_b       out  N         registered operand B to all units
//  op_start   out  7         one-hot unit start, bit i = opcode i
//  op_opcode  out  SEL_LINE  registered opcode, drives writeback select
//  wb_valid   out  1         result on rd_val valid for wb_rd
//  wb_ready   in   1         register file accepts writeback
//  wb_rd      out  RADDR     registered destination register
//  busy       out  1         state != IDLE
//  illegal    out  1         one-cycle pulse: illegal opcode consumed
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, all outputs 0 except in_ready=1;
//    in-flight instruction discarded, no writeback issued.
//  - States IDLE, EXEC, WB. in_ready = (state==IDLE), purely from state.
//  - IDLE, edge with in_valid & legal opcode: latch op_a, op_b, op_opcode, wb_rd;
//    op_start <= onehot(opcode); cnt <= LAT-1; -> EXEC.
//    LAT = MUL_LAT (2), DIV_LAT (3), else 1.
//  - IDLE, edge with in_valid & opcode>6: consumed, illegal=1 next cycle only,
//    op_*/wb_rd unchanged, stay IDLE, no op_start.
//  - EXEC: op_start cleared after its first cycle (exactly one cycle high).
//    Each edge: cnt==0 -> WB, else cnt--. EXEC lasts exactly LAT cycles, so
//    wb_valid first high LAT edges after the accept edge.
//  - WB: wb_valid=1; op_a, op_b, op_opcode, wb_rd held. Edge with wb_ready:
//    -> IDLE, wb_valid=0. No upper bound on wb_ready stall.
//  - op_a, op_b, op_opcode, wb_rd change only on a legal accept. They are stable
//    from accept until the WB handshake and retain their value in IDLE.
//  - in_valid outside IDLE is ignored (not latched, no illegal pulse).
//  - Back-to-back: next accept no earlier than the edge after the WB handshake;
//    1-cycle ops sustain one result per 3 cycles with wb_ready=1.
//  - cnt width = $clog2(max(MUL_LAT,DIV_LAT)) min 1; no wrap (loaded <= LAT-1).
// TESTING
//  1 Reset: assert rst_n=0 mid-EXEC of div -> outputs 0 at once, in_ready=1,
//    no wb_valid after release.
//  2 ADD op=0 rd=5 a=3 b=4 accepted edge k -> op_start=7'b0000001 one cycle,
//    wb_valid high from edge k+1, wb_rd=5, op_opcode=0, op_a=3, op_b=4.
//  3 DIV op=3, DIV_LAT=16 -> wb_valid rises exactly 16 edges after accept;
//    in_ready=0, busy=1 throughout.
//  4 Backpressure: MUL done, wb_ready=0 for 5 cycles, in_valid=1 with new op ->
//    wb_valid, wb_rd, op_opcode, op_a held; new op not accepted.
//  5 Illegal op=9 in IDLE -> illegal one cycle, op_start=0, no wb_valid,
//    in_ready stays 1.
//  6 MUL then XOR back-to-back -> op_start 7'b0000100 then 7'b1000000;
//    XOR accepted on the edge after the MUL WB handshake.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Single-in-flight ALU issue controller: latch, one-hot start, wait unit latency, hold for writeback.
// Latency: accept to wb_valid = 1/MUL_LAT/DIV_LAT edges; in_ready only in IDLE, WB stalls indefinitely on wb_ready.
module alu_issue_ctrl #(
  parameter int N        = 16,
  parameter int SEL_LINE = 4,
  parameter int RADDR    = 4,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_LINE-1:0] in_opcode,
  input  logic [RADDR-1:0]    in_rd,
  input  logic [N-1:0]        in_rs1_val,
  input  logic [N-1:0]        in_rs2_val,
  output logic [N-1:0]        op_a,
  output logic [N-1:0]        op_b,
  output logic [6:0]          op_start,
  output logic [SEL_LINE-1:0] op_opcode,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [RADDR-1:0]    wb_rd,
  output logic                busy,
  output logic                illegal
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0] ONE_CNT = '0;

  localparam logic [SEL_LINE-1:0] OP_MUL  = SEL_LINE'(2);
  localparam logic [SEL_LINE-1:0] OP_DIV  = SEL_LINE'(3);
  localparam logic [SEL_LINE-1:0] OP_LAST = SEL_LINE'(6);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lat_cnt;
  logic          legal;

  assign legal    = (in_opcode <= OP_LAST);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign wb_valid = (state == WB);

  // Counter preload is LAT-1 so EXEC spans exactly LAT cycles.
  always_comb begin
    lat_cnt = ONE_CNT;
    if (in_opcode == OP_MUL) lat_cnt = MUL_CNT;
    else if (in_opcode == OP_DIV) lat_cnt = DIV_CNT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_start  <= '0;
      op_opcode <= '0;
      wb_rd     <= '0;
      illegal   <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (legal) begin
              op_a      <= in_rs1_val;
              op_b      <= in_rs2_val;
              op_opcode <= in_opcode;
              wb_rd     <= in_rd;
              op_start  <= 7'b1 << in_opcode;
              cnt       <= lat_cnt;
              state     <= EXEC;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        EXEC: begin
          op_start <= '0;
          if (cnt == '0) state <= WB;
          else           cnt   <= cnt - 1'b1;
        end
        WB: begin
          if (wb_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an expected-result queue popped at each writeback.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_rd;
  logic [15:0] in_rs1_val;
  logic [15:0] in_rs2_val;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [6:0]  op_start;
  logic [3:0]  op_opcode;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_rd;
  logic        busy;
  logic        illegal;

  alu_issue_ctrl #(.N(16), .SEL_LINE(4), .RADDR(4), .MUL_LAT(3), .DIV_LAT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .op_a(op_a), .op_b(op_b), .op_start(op_start), .op_opcode(op_opcode),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] op);
    if (op == 4'd2) return 3;
    if (op == 4'd3) return 16;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [15:0] a, input logic [15:0] b);
    logic [6:0] oh;
    exp_t e;
    chk("in_ready_pre_issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1_val = a; in_rs2_val = b;
    tick();
    in_valid = 1'b0;
    oh = 7'b1 << op;
    chk("op_start_onehot", 32'(op_start), 32'(oh));
    chk("busy_after_accept", 32'(busy), 32'd1);
    e.op = op; e.rd = rd; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic wait_wb();
    int   cyc = 0;
    bit   bad = 1'b0;
    bit   start_bad = 1'b0;
    exp_t e;
    while (wb_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      if (wb_valid !== 1'b1 && (in_ready !== 1'b0 || busy !== 1'b1)) bad = 1'b1;
      if (op_start !== 7'd0) start_bad = 1'b1;
    end
    chk("wb_valid_arrives", 32'(wb_valid), 32'd1);
    chk("exec_busy_not_ready", 32'(bad), 32'd0);
    chk("op_start_single_cycle", 32'(start_bad), 32'd0);
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("wb_latency", 32'(cyc), 32'(exp_lat(e.op)));
      chk("wb_rd", 32'(wb_rd), 32'(e.rd));
      chk("op_opcode", 32'(op_opcode), 32'(e.op));
      chk("op_a", 32'(op_a), 32'(e.a));
      chk("op_b", 32'(op_b), 32'(e.b));
    end
  endtask

  task automatic handshake();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("wb_valid_after_hs", 32'(wb_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_op_start", 32'(op_start), 32'd0);
    chk("rst_op_opcode", 32'(op_opcode), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
  endtask

  initial begin
    bit saw_wb;
    exp_t e;

    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_rd = '0;
    in_rs1_val = '0; in_rs2_val = '0; wb_ready = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // ADD: single-cycle unit
    issue(4'd0, 4'd5, 16'd3, 16'd4);
    wait_wb();
    handshake();

    // DIV: long latency, busy throughout
    issue(4'd3, 4'd2, 16'd100, 16'd7);
    wait_wb();
    handshake();

    // Illegal opcode in IDLE: pulse only, state and registers untouched
    chk("illegal_pre_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_opcode = 4'd9; in_rd = 4'd1; in_rs1_val = 16'hffff; in_rs2_val = 16'hffff;
    tick();
    in_valid = 1'b0;
    chk("illegal_pulse", 32'(illegal), 32'd1);
    chk("illegal_op_start", 32'(op_start), 32'd0);
    chk("illegal_in_ready", 32'(in_ready), 32'd1);
    chk("illegal_wb_valid", 32'(wb_valid), 32'd0);
    chk("illegal_op_opcode_kept", 32'(op_opcode), 32'd3);
    chk("illegal_op_a_kept", 32'(op_a), 32'd100);
    tick();
    chk("illegal_one_cycle", 32'(illegal), 32'd0);
    chk("illegal_no_wb", 32'(wb_valid), 32'd0);

    // MUL with writeback stall while XOR is offered, then back-to-back XOR
    issue(4'd2, 4'd7, 16'd6, 16'd7);
    in_valid = 1'b1; in_opcode = 4'd6; in_rd = 4'd9; in_rs1_val = 16'h0055; in_rs2_val = 16'h000f;
    wait_wb();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_wb_valid", 32'(wb_valid), 32'd1);
      chk("stall_wb_rd", 32'(wb_rd), 32'd7);
      chk("stall_op_opcode", 32'(op_opcode), 32'd2);
      chk("stall_op_a", 32'(op_a), 32'd6);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("b2b_hs_wb_valid", 32'(wb_valid), 32'd0);
    chk("b2b_hs_in_ready", 32'(in_ready), 32'd1);
    chk("b2b_hs_op_opcode", 32'(op_opcode), 32'd2);
    chk("b2b_hs_op_start", 32'(op_start), 32'd0);
    e.op = 4'd6; e.rd = 4'd9; e.a = 16'h0055; e.b = 16'h000f;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    chk("b2b_xor_op_start", 32'(op_start), 32'h40);
    chk("b2b_xor_op_opcode", 32'(op_opcode), 32'd6);
    wait_wb();
    handshake();

    // Async reset mid-EXEC of a DIV discards it
    issue(4'd3, 4'd4, 16'd50, 16'd5);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    sb.delete();
    #3;
    rst_n = 1'b1;
    saw_wb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wb_valid !== 1'b0) saw_wb = 1'b1;
    end
    chk("no_wb_after_reset", 32'(saw_wb), 32'd0);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Recovery with SUB
    issue(4'd1, 4'd3, 16'd9, 16'd2);
    wait_wb();
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
